// File: rtl/vera_bus_top.sv
// Host bus front end: synchronizes the async phase-2 clock, samples the host bus mid-phase,
// commits one register access per phase on the phase-2 fall, and drives read data onto bus_d.
module vera_bus_top #(
  parameter int         CAPTURE_DLY = 3,
  parameter logic [7:0] ID_VALUE    = 8'h56
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       bus_phy2,
  input  logic       bus_cs_n,
  input  logic       bus_rw_n,
  input  logic [2:0] bus_a,
  inout  wire  [7:0] bus_d
);

  // state  | meaning
  // S_IDLE | waiting for a synchronized phase-2 rise
  // S_WAIT | down-counting to the bus sample point
  // S_HELD | bus sampled into cap_*, commit on the phase-2 fall
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  localparam int CW = $clog2(CAPTURE_DLY + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sync1_q, ph_s_q, ph_d_q;
  logic [2:0]     cap_a_q, cap_a_d;
  logic           cap_cs_n_q, cap_cs_n_d;
  logic           cap_rw_n_q, cap_rw_n_d;
  logic [7:0]     cap_d_q, cap_d_d;
  logic [10:0]    addr_q, addr_d;
  logic [3:0]     incr_q, incr_d;
  logic [7:0]     scratch_q [3];
  logic [7:0]     scratch_d [3];
  logic           pf_load_q, pf_load_d;
  logic [7:0]     prefetch_q, prefetch_d;
  logic [7:0]     ram_mem [2048];

  logic       rise, fall, capture_en, commit, wr, ram_we;
  logic [1:0] scr_idx;
  logic [7:0] rdata;

  assign rise = ph_s_q & ~ph_d_q;
  assign fall = ~ph_s_q & ph_d_q;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      ph_s_q     <= 1'b0;
      ph_d_q     <= 1'b0;
      cap_a_q    <= '0;
      cap_cs_n_q <= 1'b1;
      cap_rw_n_q <= 1'b0;
      cap_d_q    <= '0;
      addr_q     <= '0;
      incr_q     <= '0;
      scratch_q  <= '{default: 8'h00};
      pf_load_q  <= 1'b0;
      prefetch_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= bus_phy2;
      ph_s_q     <= sync1_q;
      ph_d_q     <= ph_s_q;
      cap_a_q    <= cap_a_d;
      cap_cs_n_q <= cap_cs_n_d;
      cap_rw_n_q <= cap_rw_n_d;
      cap_d_q    <= cap_d_d;
      addr_q     <= addr_d;
      incr_q     <= incr_d;
      scratch_q  <= scratch_d;
      pf_load_q  <= pf_load_d;
      prefetch_q <= prefetch_d;
    end
  end

  // RAM contents are intentionally not reset
  always_ff @(posedge clk25) begin
    if (ram_we) ram_mem[addr_q] <= cap_d_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (rise) begin
        state_d = S_WAIT;
        cnt_d   = CW'(CAPTURE_DLY - 1);
      end
      S_WAIT: begin
        if (fall)                 state_d = S_IDLE;
        else if (cnt_q == CW'(1)) state_d = S_HELD;
        else                      cnt_d   = cnt_q - CW'(1);
      end
      S_HELD: if (fall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == S_WAIT) && (cnt_q == CW'(1)) && !fall;
    commit     = (state_q == S_HELD) && fall && !cap_cs_n_q;
    wr         = !cap_rw_n_q;
    scr_idx    = 2'(cap_a_q - 3'd5);
    cap_a_d    = capture_en ? bus_a    : cap_a_q;
    cap_cs_n_d = capture_en ? bus_cs_n : cap_cs_n_q;
    cap_rw_n_d = capture_en ? bus_rw_n : cap_rw_n_q;
    cap_d_d    = capture_en ? bus_d    : cap_d_q;
    addr_d     = addr_q;
    incr_d     = incr_q;
    scratch_d  = scratch_q;
    ram_we     = 1'b0;
    if (commit) begin
      case (cap_a_q)
        3'd0: if (wr) addr_d[7:0]  = cap_d_q;
        3'd1: if (wr) addr_d[10:8] = cap_d_q[2:0];
        3'd2: if (wr) incr_d       = cap_d_q[3:0];
        3'd3: begin
          ram_we = wr;
          addr_d = addr_q + {7'b0, incr_q};
        end
        3'd4: ;
        default: if (wr) scratch_d[scr_idx] = cap_d_q;
      endcase
    end
    // a DATA write with INCR=0 leaves ADDR alone but must still refresh the prefetch
    pf_load_d  = (addr_d != addr_q) || ram_we;
    prefetch_d = pf_load_q ? ram_mem[addr_q] : prefetch_q;
  end

  always_comb begin
    case (bus_a)
      3'd0:    rdata = addr_q[7:0];
      3'd1:    rdata = {5'b0, addr_q[10:8]};
      3'd2:    rdata = {4'b0, incr_q};
      3'd3:    rdata = prefetch_q;
      3'd4:    rdata = ID_VALUE;
      3'd5:    rdata = scratch_q[0];
      3'd6:    rdata = scratch_q[1];
      default: rdata = scratch_q[2];
    endcase
  end

  assign bus_d = (!bus_cs_n && bus_rw_n && bus_phy2) ? rdata : 8'hzz;

endmodule

// File: tb/tb_vera_bus_top.sv
// Directed bench for vera_bus_top: host bus cycles with hand-computed register and bus_d values.
// Undriven bus_d is pulled up, so a released bus reads back as 8'hFF.
module tb_vera_bus_top;

  logic       clk25 = 1'b0;
  logic       reset;
  logic       bus_phy2;
  logic       bus_cs_n;
  logic       bus_rw_n;
  logic [2:0] bus_a;
  wire  [7:0] bus_d;
  logic       tb_oe;
  logic [7:0] tb_dout;
  logic [7:0] last_lo;
  logic [7:0] v;
  int         checks = 0;
  int         errors = 0;

  assign bus_d = tb_oe ? tb_dout : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup u_pu (bus_d[i]);
  end

  vera_bus_top #(.CAPTURE_DLY(3), .ID_VALUE(8'h56)) dut (
    .clk25    (clk25),
    .reset    (reset),
    .bus_phy2 (bus_phy2),
    .bus_cs_n (bus_cs_n),
    .bus_rw_n (bus_rw_n),
    .bus_a    (bus_a),
    .bus_d    (bus_d)
  );

  always #20 clk25 = ~clk25;

  task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One 750 ns host cycle; rd_hi is bus_d late in phase 2, last_lo is bus_d just after the fall.
  task automatic bus_cycle(input logic cs_n, input logic rw_n, input logic [2:0] a,
                           input logic [7:0] d, output logic [7:0] rd_hi);
    #100;
    bus_cs_n = cs_n;
    bus_rw_n = rw_n;
    bus_a    = a;
    #150 bus_phy2 = 1'b1;
    #100;
    if (!rw_n) begin
      tb_dout = d;
      tb_oe   = 1'b1;
    end
    #100 rd_hi = bus_d;
    #50  bus_phy2 = 1'b0;
    #10  tb_oe = 1'b0;
    #5   last_lo = bus_d;
    #5;
    bus_cs_n = 1'b1;
    bus_rw_n = 1'b1;
    #230;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus_cycle(1'b0, 1'b0, a, d, dummy);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] q);
    bus_cycle(1'b0, 1'b1, a, 8'h00, q);
  endtask

  initial begin
    reset    = 1'b1;
    bus_phy2 = 1'b0;
    bus_cs_n = 1'b1;
    bus_rw_n = 1'b1;
    bus_a    = 3'd0;
    tb_oe    = 1'b0;
    tb_dout  = 8'h00;
    last_lo  = 8'h00;
    #407;
    chk_val("bus_z_in_reset", bus_d, 8'hFF);
    reset = 1'b0;
    #200;

    rd(3'd0, v);                  chk_val("rst_addr_l", v, 8'h00);
    rd(3'd2, v);                  chk_val("rst_incr", v, 8'h00);
    wr(3'd0, 8'hAA);
    bus_cycle(1'b0, 1'b1, 3'd0, 8'h00, v);
    chk_val("addr_l_read", v, 8'hAA);
    chk_val("bus_z_phy2_low", last_lo, 8'hFF);

    wr(3'd0, 8'hFE);
    wr(3'd1, 8'h07);
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h11);
    wr(3'd3, 8'h22);
    wr(3'd3, 8'h33);
    rd(3'd0, v);                  chk_val("wrap_addr_l", v, 8'h01);
    rd(3'd1, v);                  chk_val("wrap_addr_h", v, 8'h00);
    wr(3'd0, 8'hFE);
    wr(3'd1, 8'h07);
    rd(3'd3, v);                  chk_val("data_rd0", v, 8'h11);
    rd(3'd3, v);                  chk_val("data_rd1", v, 8'h22);
    rd(3'd3, v);                  chk_val("data_rd2", v, 8'h33);
    rd(3'd0, v);                  chk_val("rd_incr_addr", v, 8'h01);

    rd(3'd4, v);                  chk_val("id", v, 8'h56);
    wr(3'd4, 8'h00);
    rd(3'd4, v);                  chk_val("id_after_wr", v, 8'h56);

    wr(3'd1, 8'hFF);
    wr(3'd2, 8'hFF);
    rd(3'd1, v);                  chk_val("addr_h_mask", v, 8'h07);
    rd(3'd2, v);                  chk_val("incr_mask", v, 8'h0F);
    wr(3'd7, 8'h5A);
    wr(3'd5, 8'h3C);
    rd(3'd7, v);                  chk_val("scratch7", v, 8'h5A);
    rd(3'd5, v);                  chk_val("scratch5", v, 8'h3C);

    bus_cycle(1'b1, 1'b0, 3'd7, 8'h00, v);
    rd(3'd7, v);                  chk_val("cs_high_no_wr", v, 8'h5A);
    bus_cycle(1'b1, 1'b1, 3'd7, 8'h00, v);
    chk_val("cs_high_bus_z", v, 8'hFF);

    // write to reg 6, reset asserted mid-phase and held past the fall
    #100;
    bus_cs_n = 1'b0;
    bus_rw_n = 1'b0;
    bus_a    = 3'd6;
    #150 bus_phy2 = 1'b1;
    #100;
    tb_dout = 8'h77;
    tb_oe   = 1'b1;
    reset   = 1'b1;
    #150 bus_phy2 = 1'b0;
    #10  tb_oe = 1'b0;
    #10;
    bus_cs_n = 1'b1;
    bus_rw_n = 1'b1;
    #50  reset = 1'b0;
    #200;
    rd(3'd6, v);                  chk_val("rst_mid_wr", v, 8'h00);
    rd(3'd7, v);                  chk_val("rst_scratch7", v, 8'h00);
    rd(3'd5, v);                  chk_val("rst_scratch5", v, 8'h00);
    rd(3'd0, v);                  chk_val("rst_addr_l2", v, 8'h00);
    rd(3'd1, v);                  chk_val("rst_addr_h2", v, 8'h00);
    rd(3'd2, v);                  chk_val("rst_incr2", v, 8'h00);
    rd(3'd3, v);                  chk_val("rst_prefetch", v, 8'h00);

    wr(3'd0, 8'h10);
    wr(3'd3, 8'h01);
    wr(3'd3, 8'h02);
    rd(3'd0, v);                  chk_val("incr0_addr_l", v, 8'h10);
    rd(3'd1, v);                  chk_val("incr0_addr_h", v, 8'h00);
    rd(3'd3, v);                  chk_val("incr0_data", v, 8'h02);
    rd(3'd3, v);                  chk_val("incr0_data2", v, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
